// File: rtl/alu_mc_pkg.sv
// Shared types and op classification for the multi-cycle execute ALU (alu_mc).
// DIV/DIVU/REM/REMU are only built when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11,
    ALU_DIVU = 4'd12,
    ALU_REM  = 4'd13,
    ALU_REMU = 4'd14,
    ALU_RSVD = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_mc_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_multicycle(input alu_op_e op);
    return is_shift(op) || (op == ALU_MUL) || is_div(op);
  endfunction

endpackage

// File: rtl/alu_mc_div.sv
// Restoring divider for alu_mc, one quotient bit per cycle, DW cycles including the start cycle.
// Only instantiated when ALU_MC_DIV_EN is defined; done is high during the final step cycle.
module alu_mc_div
  import alu_mc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_signed,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CW = $clog2(DW) + 1;

  logic          running_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] q_reg, r_reg, d_reg, dividend_reg;
  logic          neg_q_reg, neg_r_reg, dz_reg;

  logic [DW-1:0] mag_a, mag_b, src_q, src_r, src_d, q_step, r_step;
  logic [DW:0]   r_sh, diff;

  always_comb begin
    mag_a = (is_signed && dividend[DW-1]) ? -dividend : dividend;
    mag_b = (is_signed && divisor[DW-1]) ? -divisor : divisor;
    // The first quotient bit is produced on the start edge itself.
    src_q = start ? mag_a : q_reg;
    src_r = start ? '0 : r_reg;
    src_d = start ? mag_b : d_reg;
    r_sh  = {src_r, src_q[DW-1]};
    diff  = r_sh - {1'b0, src_d};
    if (!diff[DW]) begin
      r_step = diff[DW-1:0];
      q_step = {src_q[DW-2:0], 1'b1};
    end else begin
      r_step = r_sh[DW-1:0];
      q_step = {src_q[DW-2:0], 1'b0};
    end
  end

  assign done      = running_reg && (cnt_reg == '0);
  assign quotient  = dz_reg ? '1 : (neg_q_reg ? -q_step : q_step);
  assign remainder = dz_reg ? dividend_reg : (neg_r_reg ? -r_step : r_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      running_reg  <= 1'b0;
      cnt_reg      <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      d_reg        <= '0;
      dividend_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_reg       <= 1'b0;
    end else if (start) begin
      running_reg  <= 1'b1;
      cnt_reg      <= CW'(DW - 2);
      q_reg        <= q_step;
      r_reg        <= r_step;
      d_reg        <= mag_b;
      dividend_reg <= dividend;
      neg_q_reg    <= is_signed && (dividend[DW-1] ^ divisor[DW-1]);
      neg_r_reg    <= is_signed && dividend[DW-1];
      dz_reg       <= (divisor == '0);
    end else if (running_reg) begin
      q_reg   <= q_step;
      r_reg   <= r_step;
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == '0) running_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU with valid/ready handshakes, iterative shifter and multiplier.
// Define ALU_MC_DIV_EN to build the iterative divider; otherwise ops 11-14 report illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DW         = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [DW-1:0]       operand_a_i,
  input  logic [DW-1:0]       operand_b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DW-1:0]       result_o,
  output logic                illegal_o,
  output logic                busy_o
);

  localparam int SW      = $clog2(DW);
  localparam int CW      = SW + 2;
  localparam int STEP_LG = $clog2(SHIFT_STEP);

  alu_mc_state_e state_reg;
  alu_op_e       op_reg;
  logic [DW-1:0] a_reg, b_reg, acc_reg, result_reg;
  logic          illegal_reg;
  logic [CW-1:0] cnt_reg;

  alu_op_e       op_in, src_op;
  logic [SW-1:0] shamt;
  logic [CW-1:0] shift_n, step_amt;
  logic [DW-1:0] simple_res, src_a, src_b, src_acc, shift_res, mul_acc;
  logic          in_illegal, accept;

  assign op_in   = alu_op_e'(op_i);
  assign shamt   = operand_b_i[SW-1:0];
  assign shift_n = (CW'(shamt) + CW'(SHIFT_STEP - 1)) >> STEP_LG;
  assign accept  = in_valid_i && (state_reg == IDLE);

`ifdef ALU_MC_DIV_EN
  assign in_illegal = (op_in == ALU_RSVD);
`else
  assign in_illegal = (op_in == ALU_RSVD) || is_div(op_in);
`endif

  always_comb begin
    simple_res = '0;
    case (op_in)
      ALU_ADD:  simple_res = operand_a_i + operand_b_i;
      ALU_SUB:  simple_res = operand_a_i + ~operand_b_i + DW'(1);
      ALU_SLT:  simple_res = DW'($signed(operand_a_i) < $signed(operand_b_i));
      ALU_SLTU: simple_res = DW'(operand_a_i < operand_b_i);
      ALU_XOR:  simple_res = operand_a_i ^ operand_b_i;
      ALU_OR:   simple_res = operand_a_i | operand_b_i;
      ALU_AND:  simple_res = operand_a_i & operand_b_i;
      default:  simple_res = '0;
    endcase
  end

  // One shift/multiply step; in IDLE it runs on the incoming operands so the accept edge counts.
  always_comb begin
    src_op   = (state_reg == IDLE) ? op_in : op_reg;
    src_a    = (state_reg == IDLE) ? operand_a_i : a_reg;
    src_b    = (state_reg == IDLE) ? (is_shift(op_in) ? DW'(shamt) : operand_b_i) : b_reg;
    src_acc  = (state_reg == IDLE) ? '0 : acc_reg;
    step_amt = (src_b > DW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : src_b[CW-1:0];
    case (src_op)
      ALU_SLL: shift_res = src_a << step_amt;
      ALU_SRA: shift_res = $unsigned($signed(src_a) >>> step_amt);
      default: shift_res = src_a >> step_amt;
    endcase
    mul_acc = src_acc + (src_b[0] ? src_a : '0);
  end

`ifdef ALU_MC_DIV_EN
  logic          div_done;
  logic [DW-1:0] div_q, div_r;

  alu_mc_div #(.DW(DW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div(op_in)),
    .is_signed ((op_in == ALU_DIV) || (op_in == ALU_REM)),
    .dividend  (operand_a_i),
    .divisor   (operand_b_i),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_reg      <= ALU_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          op_reg      <= op_in;
          illegal_reg <= in_illegal;
          result_reg  <= simple_res;
          a_reg       <= src_a;
          b_reg       <= src_b;
          acc_reg     <= '0;
          if (in_illegal || !is_multicycle(op_in)) begin
            state_reg <= DONE;
          end else if (is_shift(op_in)) begin
            a_reg   <= shift_res;
            b_reg   <= src_b - DW'(step_amt);
            cnt_reg <= shift_n - CW'(2);
            if (shift_n <= CW'(1)) begin
              result_reg <= shift_res;
              state_reg  <= DONE;
            end else begin
              state_reg <= BUSY;
            end
          end else if (op_in == ALU_MUL) begin
            acc_reg   <= mul_acc;
            a_reg     <= src_a << 1;
            b_reg     <= src_b >> 1;
            cnt_reg   <= CW'(DW - 2);
            state_reg <= BUSY;
          end else begin
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (is_shift(op_reg)) begin
            a_reg <= shift_res;
            b_reg <= b_reg - DW'(step_amt);
            if (cnt_reg == '0) begin
              result_reg <= shift_res;
              state_reg  <= DONE;
            end
          end else if (op_reg == ALU_MUL) begin
            acc_reg <= mul_acc;
            a_reg   <= a_reg << 1;
            b_reg   <= b_reg >> 1;
            if (cnt_reg == '0) begin
              result_reg <= mul_acc;
              state_reg  <= DONE;
            end
          end else begin
`ifdef ALU_MC_DIV_EN
            if (div_done) begin
              result_reg <= ((op_reg == ALU_REM) || (op_reg == ALU_REMU)) ? div_r : div_q;
              state_reg  <= DONE;
            end
`else
            state_reg <= DONE;
`endif
          end
        end
        DONE: if (out_ready_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_reg == IDLE);
  assign out_valid_o = (state_reg == DONE);
  assign busy_o      = (state_reg == BUSY) || (state_reg == DONE);
  assign result_o    = result_reg;
  assign illegal_o   = illegal_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (DW=32, SHIFT_STEP=4); divider vectors follow ALU_MC_DIV_EN.
`timescale 1ns/1ps
module tb_alu_mc;

  localparam int DW   = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [3:0]    op;
  logic [DW-1:0] a, b, result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.DW(DW), .SHIFT_STEP(STEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .operand_a_i (a),
    .operand_b_i (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .illegal_o   (illegal),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, count edges from the accept edge to out_valid, hold DONE, then release.
  task automatic run_op(input string name, input logic [3:0] o, input logic [DW-1:0] x,
                        input logic [DW-1:0] y, input logic [DW-1:0] exp_res,
                        input logic exp_ill, input int exp_n, input int hold);
    int n;
    chk({name, " in_ready"}, DW'(in_ready), DW'(1));
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
    end while (!out_valid && n < 200);
    chk({name, " latency"}, DW'(n), DW'(exp_n));
    chk({name, " result"}, result, exp_res);
    chk({name, " illegal"}, DW'(illegal), DW'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " hold result"}, result, exp_res);
      chk({name, " hold in_ready"}, DW'(in_ready), DW'(0));
      chk({name, " hold out_valid"}, DW'(out_valid), DW'(1));
    end
    $display("op=%0d a=%h b=%h -> result=%h illegal=%0b cycles=%0d", o, x, y, result, illegal, n);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " release"}, DW'({out_valid, busy, in_ready}), DW'(3'b001));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", DW'({in_ready, out_valid, illegal, busy}), DW'(4'b1000));
    chk("reset result", result, '0);
    rst = 1'b0;

    run_op("ADD ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1, 0);
    run_op("SUB neg",  4'd1, 32'h00000005, 32'hFFFFFFFD, 32'h00000008, 1'b0, 1, 0);
    run_op("SUB wrap", 4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1, 0);
    run_op("SLT",      4'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 0);
    run_op("SLTU",     4'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0);
    run_op("XOR",      4'd5, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1, 0);
    run_op("OR",       4'd8, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1, 0);
    run_op("AND",      4'd9, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, 0);
    run_op("SRA 5",    4'd7, 32'h80000000, 32'h00000005, 32'hFC000000, 1'b0, 2, 0);
    run_op("SRA 0",    4'd7, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1, 0);
    run_op("SRA 3",    4'd7, 32'h40000000, 32'h00000003, 32'h08000000, 1'b0, 1, 0);
    run_op("SRA 31",   4'd7, 32'hF0000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 8, 0);
    run_op("SLL 7",    4'd2, 32'h00000001, 32'h00000007, 32'h00000080, 1'b0, 2, 0);
    run_op("SRL 31",   4'd6, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 8, 0);
    run_op("MUL -1*-1", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32, 3);
    run_op("MUL small", 4'd10, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0, 32, 0);
    run_op("MUL wrap",  4'd10, 32'h80000000, 32'h00000003, 32'h80000000, 1'b0, 32, 0);
    run_op("RSVD",      4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1, 0);
`ifdef ALU_MC_DIV_EN
    run_op("DIV -7/2",   4'd11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 32, 0);
    run_op("REM -7/2",   4'd13, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 32, 0);
    run_op("DIVU 5/0",   4'd12, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32, 0);
    run_op("REMU 5/0",   4'd14, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 32, 0);
    run_op("DIV ovf",    4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32, 0);
    run_op("REM ovf",    4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32, 0);
    run_op("DIVU 100/7", 4'd12, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 32, 0);
    run_op("REMU 100/7", 4'd14, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 32, 0);
`else
    run_op("DIV off",  4'd11, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 1'b1, 1, 0);
    run_op("DIVU off", 4'd12, 32'h00000005, 32'h00000001, 32'h00000000, 1'b1, 1, 0);
    run_op("REM off",  4'd13, 32'h00000007, 32'h00000002, 32'h00000000, 1'b1, 1, 0);
    run_op("REMU off", 4'd14, 32'h00000007, 32'h00000002, 32'h00000000, 1'b1, 1, 0);
`endif

    // Leave a nonzero result in place, then abort a MUL mid-flight.
    run_op("ADD pre",  4'd0, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1, 0);
    op = 4'd10; a = 32'h00000007; b = 32'h00000009; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid MUL busy", DW'({busy, out_valid}), DW'(2'b10));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort flags", DW'({in_ready, out_valid, busy}), DW'(3'b100));
    chk("abort result", result, '0);
    $display("reset during MUL -> in_ready=%0b out_valid=%0b result=%h", in_ready, out_valid, result);
    run_op("ADD post", 4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
